// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: sample controls in, match status and FSM probes out.
interface seq_detector_param_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(LEN + 1);

  logic             x;
  logic             en;
  logic             overlap;
  logic             clear;
  logic             y;
  logic [SW-1:0]    cs;
  logic [SW-1:0]    ns;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output x, en, overlap, clear,
                  input  y, cs, ns, match_cnt, cnt_sat);
  modport slave  (input  x, en, overlap, clear,
                  output y, cs, ns, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial pattern detector with KMP-style next state,
// run-time overlap mode, sample enable, sync clear and saturating match counter.
module seq_detector_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detector_param_if.slave bus
);
  localparam int SW = $clog2(LEN + 1);

  logic [SW-1:0]    cs_q;
  logic [SW-1:0]    ns_d;
  logic [LEN-2:0]   hist_q;
  logic [CNT_W-1:0] cnt_q;
  logic             y_q;
  logic [LEN-1:0]   win;

  // Newest LEN bits including the bit currently on x, newest in bit 0.
  assign win = {hist_q, bus.x};

  // Largest prefix length k reachable from c_eff whose bits match the window tail.
  always_comb begin
    int   c_eff;
    logic hit;
    ns_d  = '0;
    hit   = 1'b0;
    c_eff = int'(cs_q);
    if (cs_q == SW'(LEN) && !bus.overlap) c_eff = 0;
    for (int k = 1; k <= LEN; k++) begin
      hit = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (win[i] != PATTERN[LEN-k+i]) hit = 1'b0;
      end
      if (hit && (k <= c_eff + 1)) ns_d = SW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q   <= '0;
      hist_q <= '0;
      cnt_q  <= '0;
      y_q    <= 1'b0;
    end else if (bus.clear) begin
      cs_q   <= '0;
      hist_q <= '0;
      cnt_q  <= '0;
      y_q    <= 1'b0;
    end else if (bus.en) begin
      cs_q   <= ns_d;
      hist_q <= win[LEN-2:0];
      y_q    <= (ns_d == SW'(LEN));
      if (ns_d == SW'(LEN) && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.y         = y_q;
  assign bus.cs        = cs_q;
  assign bus.ns        = ns_d;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = &cnt_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: 1011 detector with 8-bit and 2-bit counters.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_param_if #(.LEN(4), .CNT_W(8)) b1 ();
  seq_detector_param_if #(.LEN(4), .CNT_W(2)) b2 ();

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic s1(input logic b);
    @(negedge clk); b1.x = b;
    @(posedge clk); #1;
  endtask

  task automatic s2(input logic b);
    @(negedge clk); b2.x = b;
    @(posedge clk); #1;
  endtask

  task automatic cl1();
    @(negedge clk); b1.clear = 1'b1;
    @(posedge clk); #1; b1.clear = 1'b0;
  endtask

  task automatic cl2();
    @(negedge clk); b2.clear = 1'b1;
    @(posedge clk); #1; b2.clear = 1'b0;
  endtask

  initial begin
    logic        stream [7];
    int          cs_ov  [7];
    int          cs_no  [7];
    logic [63:0] seq;
    logic [3:0]  mwin;
    int          since;
    int          mcnt;
    logic        hit;

    stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    cs_ov  = '{1, 2, 3, 4, 2, 3, 4};
    cs_no  = '{1, 2, 3, 4, 0, 1, 1};
    seq    = 64'hB6D6_B5B6_ED2B_6DB5;

    rst = 1'b0;
    b1.x = 1'b0; b1.en = 1'b1; b1.overlap = 1'b1; b1.clear = 1'b0;
    b2.x = 1'b0; b2.en = 1'b1; b2.overlap = 1'b1; b2.clear = 1'b0;
    #12;
    chk("reset_cs",  32'(b1.cs), 0);
    chk("reset_y",   32'(b1.y), 0);
    chk("reset_cnt", 32'(b1.match_cnt), 0);
    chk("reset_sat", 32'(b1.cnt_sat), 0);
    chk("reset_cnt2", 32'(b2.match_cnt), 0);
    @(negedge clk); rst = 1'b1;

    // Overlapping: second match reuses the trailing "1"
    for (int i = 0; i < 7; i++) begin
      s1(stream[i]);
      chk($sformatf("ov_cs%0d", i), 32'(b1.cs), 32'(cs_ov[i]));
      chk($sformatf("ov_y%0d", i), 32'(b1.y), (cs_ov[i] == 4) ? 1 : 0);
    end
    chk("ov_cnt", 32'(b1.match_cnt), 2);

    b1.en = 1'b0;
    cl1();
    chk("clr_noen_cs",  32'(b1.cs), 0);
    chk("clr_noen_cnt", 32'(b1.match_cnt), 0);
    chk("clr_noen_y",   32'(b1.y), 0);
    b1.en = 1'b1;

    // Non-overlapping: state after a match restarts from an empty prefix
    b1.overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s1(stream[i]);
      chk($sformatf("no_cs%0d", i), 32'(b1.cs), 32'(cs_no[i]));
      chk($sformatf("no_y%0d", i), 32'(b1.y), (cs_no[i] == 4) ? 1 : 0);
    end
    chk("no_cnt", 32'(b1.match_cnt), 1);

    // Enable hold with x toggling, ns tracks x combinationally
    b1.overlap = 1'b1;
    cl1();
    s1(1'b1); s1(1'b0); s1(1'b1);
    chk("hold_pre_cs", 32'(b1.cs), 3);
    b1.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); b1.x = (i % 2 == 0);
      #1;
      chk($sformatf("hold_ns%0d", i), 32'(b1.ns), (i % 2 == 0) ? 4 : 2);
      @(posedge clk); #1;
      chk($sformatf("hold_cs%0d", i), 32'(b1.cs), 3);
    end
    b1.en = 1'b1;
    s1(1'b1);
    chk("hold_match_cs", 32'(b1.cs), 4);
    chk("hold_match_y",  32'(b1.y), 1);
    chk("hold_match_cnt", 32'(b1.match_cnt), 1);
    b1.en = 1'b0;
    s1(1'b0);
    chk("hold_y_stays", 32'(b1.y), 1);
    chk("hold_cnt_stays", 32'(b1.match_cnt), 1);
    b1.en = 1'b1;

    // Asynchronous reset in the middle of a cycle
    s1(1'b0); s1(1'b1);
    chk("pre_rst_cs", 32'(b1.cs), 3);
    @(negedge clk); #2; rst = 1'b0; #1;
    chk("async_rst_cs",  32'(b1.cs), 0);
    chk("async_rst_y",   32'(b1.y), 0);
    chk("async_rst_cnt", 32'(b1.match_cnt), 0);
    @(negedge clk); rst = 1'b1;

    // Saturating 2-bit counter
    for (int r = 0; r < 5; r++) begin
      s2(1'b1); s2(1'b0); s2(1'b1); s2(1'b1);
      chk($sformatf("sat_cnt%0d", r), 32'(b2.match_cnt), (r < 3) ? 32'(r + 1) : 3);
    end
    chk("sat_flag", 32'(b2.cnt_sat), 1);
    chk("sat_y",    32'(b2.y), 1);
    cl2();
    chk("sat_clr_cnt", 32'(b2.match_cnt), 0);
    chk("sat_clr_cs",  32'(b2.cs), 0);
    chk("sat_clr_flag", 32'(b2.cnt_sat), 0);

    // 64-bit sequence against a window/spacing reference model
    for (int ov = 0; ov < 2; ov++) begin
      b1.overlap = (ov == 1);
      cl1();
      mwin = 4'b0000; since = 0; mcnt = 0;
      for (int i = 63; i >= 0; i--) begin
        s1(seq[i]);
        mwin  = {mwin[2:0], seq[i]};
        since = since + 1;
        hit   = (mwin == 4'b1011) && (since >= 4);
        if (hit) begin
          mcnt = mcnt + 1;
          if (ov == 0) since = 0;
        end
        chk($sformatf("seq_ov%0d_y%0d", ov, i), 32'(b1.y), 32'(hit));
      end
      chk($sformatf("seq_ov%0d_cnt", ov), 32'(b1.match_cnt), 32'(mcnt));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
